decp_param: RTL and testbench

DECP_PARAM -- requirements
Module: decp_param

---
 rtl/decp_param.sv | 218 +++++++++++++++++++++
 tb/tb_decp_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decp_param.sv
// ---------------------------------------------------------------------------
// decp_param -- cyclic-prefix remover for a framed OFDM sample stream.
//
// A frame is NSYM symbols. Each symbol is a cyclic prefix of cp_len samples
// followed by NFFT useful samples. The prefix samples are dropped. The useful
// samples are forwarded with symbol start/end markers and the symbol index.
// All outputs are registered, so there is exactly one cycle of latency.
//
// Ports
//   clk              in   single clock, rising edge
//   rst              in   asynchronous active-low reset
//   di_re, di_im     in   [DW-1:0]  input I/Q sample
//   di_vld           in   input sample valid
//   di_sof           in   start of frame (first CP sample of symbol 0),
//                         qualified by di_vld
//   cp_len           in   [CPW-1:0] CP length, sampled only on a qualified di_sof
//   do_re, do_im     out  [DW-1:0]  CP-stripped sample, held while do_vld=0
//   do_vld           out  output valid
//   do_sos, do_eos   out  first / last useful sample of a symbol
//   do_sym           out  [SW-1:0]  symbol index of the current output sample
//   err_cp           out  one-cycle pulse: cp_len above NCP_MAX, clamped
//   err_resync       out  one-cycle pulse: di_sof arrived in the middle of a frame
// ---------------------------------------------------------------------------
module decp_param #(
  parameter int  DW      = 12,
  parameter int  NFFT    = 512,
  parameter int  NCP_MAX = 32,
  parameter int  NSYM    = 7,
  localparam int CPW     = $clog2(NCP_MAX + 1),
  localparam int SW      = $clog2(NSYM),
  localparam int NW      = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  input  logic          di_vld,
  input  logic          di_sof,
  input  logic [CPW-1:0] cp_len,
  output logic [DW-1:0] do_re,
  output logic [DW-1:0] do_im,
  output logic          do_vld,
  output logic          do_sos,
  output logic          do_eos,
  output logic [SW-1:0] do_sym,
  output logic          err_cp,
  output logic          err_resync
);

  // The sample counter has to cover both the CP and the useful part.
  localparam int CNTW = (CPW > NW) ? CPW : NW;

  localparam logic [CNTW-1:0] LAST_SAMP = CNTW'(NFFT - 1);
  localparam logic [CPW-1:0]  CP_MAX    = CPW'(NCP_MAX);
  localparam logic [SW-1:0]   LAST_SYM  = SW'(NSYM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CP   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_samp_cnt;
  logic [CNTW-1:0] w_samp_nxt;
  logic [CNTW-1:0] w_samp_inc;
  logic [SW-1:0]   r_sym_cnt;
  logic [SW-1:0]   w_sym_nxt;
  logic [CPW-1:0]  r_cp_reg;
  logic [CPW-1:0]  w_cp_nxt;
  logic [CPW-1:0]  w_cp_clamp;
  logic            w_fwd;
  logic            w_sos;
  logic            w_eos;
  logic [SW-1:0]   w_sym_out;
  logic            w_err_cp;
  logic            w_err_rs;

  logic [DW-1:0]   r_do_re;
  logic [DW-1:0]   r_do_im;
  logic            r_do_vld;
  logic            r_do_sos;
  logic            r_do_eos;
  logic [SW-1:0]   r_do_sym;
  logic            r_err_cp;
  logic            r_err_rs;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and output-decode logic.
  always_comb begin
    w_state_nxt = r_state;
    w_samp_nxt  = r_samp_cnt;
    w_sym_nxt   = r_sym_cnt;
    w_cp_nxt    = r_cp_reg;
    w_fwd       = 1'b0;
    w_sos       = 1'b0;
    w_eos       = 1'b0;
    w_sym_out   = r_sym_cnt;
    w_err_cp    = 1'b0;
    w_err_rs    = 1'b0;
    w_samp_inc  = r_samp_cnt + CNTW'(1);
    w_cp_clamp  = (cp_len > CP_MAX) ? CP_MAX : cp_len;

    if (di_vld && di_sof) begin
      // A start of frame restarts everything, even in the middle of a frame.
      // The sof sample itself is CP sample 0 (or useful sample 0 when cp=0).
      w_cp_nxt  = w_cp_clamp;
      w_sym_nxt = '0;
      w_err_cp  = (cp_len > CP_MAX);
      w_err_rs  = (r_state != S_IDLE);
      if (w_cp_clamp == '0) begin
        w_state_nxt = S_DATA;
        w_samp_nxt  = CNTW'(1);
        w_fwd       = 1'b1;
        w_sos       = 1'b1;
        w_eos       = (LAST_SAMP == '0);
        w_sym_out   = '0;
      end else if (w_cp_clamp == CPW'(1)) begin
        w_state_nxt = S_DATA;
        w_samp_nxt  = '0;
      end else begin
        w_state_nxt = S_CP;
        w_samp_nxt  = CNTW'(1);
      end
    end else if (di_vld) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_CP: begin
          // samp_cnt holds the number of CP samples already dropped.
          if (w_samp_inc == CNTW'(r_cp_reg)) begin
            w_state_nxt = S_DATA;
            w_samp_nxt  = '0;
          end else begin
            w_samp_nxt  = w_samp_inc;
          end
        end
        S_DATA: begin
          w_fwd = 1'b1;
          w_sos = (r_samp_cnt == '0);
          if (r_samp_cnt == LAST_SAMP) begin
            w_eos      = 1'b1;
            w_samp_nxt = '0;
            if (r_sym_cnt == LAST_SYM) begin
              w_state_nxt = S_IDLE;
              w_sym_nxt   = '0;
            end else begin
              w_sym_nxt   = r_sym_cnt + SW'(1);
              w_state_nxt = (r_cp_reg == '0) ? S_DATA : S_CP;
            end
          end else begin
            w_samp_nxt = w_samp_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_samp_nxt  = '0;
          w_sym_nxt   = '0;
        end
      endcase
    end else begin
      // Input gap: every counter and the state simply hold.
      w_state_nxt = r_state;
    end
  end

  // Counters, CP register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_samp_cnt <= '0;
      r_sym_cnt  <= '0;
      r_cp_reg   <= '0;
      r_do_re    <= '0;
      r_do_im    <= '0;
      r_do_vld   <= 1'b0;
      r_do_sos   <= 1'b0;
      r_do_eos   <= 1'b0;
      r_do_sym   <= '0;
      r_err_cp   <= 1'b0;
      r_err_rs   <= 1'b0;
    end else begin
      r_samp_cnt <= w_samp_nxt;
      r_sym_cnt  <= w_sym_nxt;
      r_cp_reg   <= w_cp_nxt;
      r_do_vld   <= w_fwd;
      r_do_sos   <= w_sos;
      r_do_eos   <= w_eos;
      r_err_cp   <= w_err_cp;
      r_err_rs   <= w_err_rs;
      // Data and symbol index hold their last value across gaps.
      if (w_fwd) begin
        r_do_re  <= di_re;
        r_do_im  <= di_im;
        r_do_sym <= w_sym_out;
      end
    end
  end

  assign do_re      = r_do_re;
  assign do_im      = r_do_im;
  assign do_vld     = r_do_vld;
  assign do_sos     = r_do_sos;
  assign do_eos     = r_do_eos;
  assign do_sym     = r_do_sym;
  assign err_cp     = r_err_cp;
  assign err_resync = r_err_rs;

endmodule

// File: tb/tb_decp_param.sv
// ---------------------------------------------------------------------------
// tb_decp_param -- scoreboard bench for decp_param with default parameters.
// The stimulus side knows the frame layout it generates (cp, symbol, offset)
// and pushes the expected output sample, including the cycle it must appear
// in, into a queue. A separate monitor pops and compares on every do_vld.
// ---------------------------------------------------------------------------
module tb_decp_param;

  localparam int DW   = 12;
  localparam int NFFT = 512;
  localparam int CPW  = 6;
  localparam int SW   = 3;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sos;
    logic          eos;
    logic [SW-1:0] sym;
    logic [31:0]   cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  di_re = '0;
  logic [DW-1:0]  di_im = '0;
  logic           di_vld = 1'b0;
  logic           di_sof = 1'b0;
  logic [CPW-1:0] cp_len = '0;
  logic [DW-1:0]  do_re;
  logic [DW-1:0]  do_im;
  logic           do_vld;
  logic           do_sos;
  logic           do_eos;
  logic [SW-1:0]  do_sym;
  logic           err_cp;
  logic           err_resync;

  exp_t q[$];
  int   cyc = 0;
  int   seq = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_vld = 0;
  int   n_sos = 0;
  int   n_eos = 0;
  int   n_ecp = 0;
  int   n_ers = 0;
  logic [2*DW-1:0] last_out = '0;

  decp_param dut (
    .clk(clk), .rst(rst),
    .di_re(di_re), .di_im(di_im), .di_vld(di_vld), .di_sof(di_sof),
    .cp_len(cp_len),
    .do_re(do_re), .do_im(do_im), .do_vld(do_vld),
    .do_sos(do_sos), .do_eos(do_eos), .do_sym(do_sym),
    .err_cp(err_cp), .err_resync(err_resync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, 64'({do_re, do_im, do_vld, do_sos, do_eos, do_sym, err_cp, err_resync}), 64'd0);
  endtask

  // Monitor: compares every output sample with the scoreboard head.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_out = '0;
      end else if (do_vld) begin
        n_vld = n_vld + 1;
        if (do_sos) n_sos = n_sos + 1;
        if (do_eos) n_eos = n_eos + 1;
        if (q.size() == 0) begin
          chk("do_vld_with_empty_queue", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          a = '{re: do_re, im: do_im, sos: do_sos, eos: do_eos, sym: do_sym, cyc: 32'(cyc)};
          chk("out_sample{re,im,sos,eos,sym,cyc}", 64'(a), 64'(e));
        end
        last_out = {do_re, do_im};
      end else begin
        chk("hold_re_im_in_gap", 64'({do_re, do_im}), 64'(last_out));
      end
      if (err_cp) n_ecp = n_ecp + 1;
      if (err_resync) n_ers = n_ers + 1;
    end
  end

  // Drive one valid sample; push its expected output when it is forwarded.
  task automatic drive_sample(input logic sof, input logic [CPW-1:0] cpl, input bit fwd,
                              input bit sos, input bit eos, input int sym);
    exp_t e;
    @(posedge clk);
    #1;
    di_vld = 1'b1;
    di_sof = sof;
    cp_len = cpl;
    di_re  = DW'(seq);
    di_im  = DW'(seq * 5 + 291);
    seq    = seq + 1;
    if (fwd) begin
      e.re  = di_re;
      e.im  = di_im;
      e.sos = sos;
      e.eos = eos;
      e.sym = SW'(sym);
      e.cyc = 32'(cyc + 1);
      q.push_back(e);
    end
  endtask

  // Idle cycle with junk on the unqualified inputs.
  task automatic idle_cycle();
    @(posedge clk);
    #1;
    di_vld = 1'b0;
    di_sof = 1'($urandom_range(0, 1));
    cp_len = CPW'($urandom_range(0, 63));
    di_re  = DW'($urandom_range(0, 4095));
    di_im  = DW'($urandom_range(0, 4095));
  endtask

  // Stream 'total' samples of a frame whose effective CP is cp_eff.
  task automatic run_frame(input logic [CPW-1:0] cpl_in, input int cp_eff,
                           input int total, input bit gaps);
    int slen;
    int sym;
    int k;
    slen = cp_eff + NFFT;
    for (int n = 0; n < total; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) idle_cycle();
      end
      sym = n / slen;
      k   = n % slen;
      drive_sample(n == 0, (n == 0) ? cpl_in : CPW'($urandom_range(0, 63)),
                   k >= cp_eff, k == cp_eff, k == slen - 1, sym);
    end
  endtask

  // Let the last sample come out and check that the scoreboard drained.
  task automatic settle(input string name);
    @(posedge clk);
    #1;
    di_vld = 1'b0;
    di_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic chk_counts(input string name, input int v0, input int s0, input int e0,
                            input int c0, input int r0, input int nv, input int ns,
                            input int nc, input int nr);
    chk({name, "_vld_count"}, 64'(n_vld - v0), 64'(nv));
    chk({name, "_sos_count"}, 64'(n_sos - s0), 64'(ns));
    chk({name, "_eos_count"}, 64'(n_eos - e0), 64'(ns));
    chk({name, "_err_cp_count"}, 64'(n_ecp - c0), 64'(nc));
    chk({name, "_err_resync_count"}, 64'(n_ers - r0), 64'(nr));
  endtask

  initial begin
    int v0, s0, e0, c0, r0;

    // Power-on reset.
    #1 rst = 1'b0;
    #2 chk_outputs_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Defaults, CP 32, contiguous.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd32, 32, 7 * 544, 1'b0);
    settle("cp32_drained");
    chk_counts("cp32", v0, s0, e0, c0, r0, 3584, 7, 0, 0);

    // CP 0: every sample forwarded, sos on the first input sample.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd0, 0, 7 * 512, 1'b0);
    settle("cp0_drained");
    chk_counts("cp0", v0, s0, e0, c0, r0, 3584, 7, 0, 0);

    // CP 1: sos on the second input sample.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd1, 1, 7 * 513, 1'b0);
    settle("cp1_drained");
    chk_counts("cp1", v0, s0, e0, c0, r0, 3584, 7, 0, 0);

    // CP 32 with random input gaps.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd32, 32, 7 * 544, 1'b1);
    settle("gaps_drained");
    chk_counts("gaps", v0, s0, e0, c0, r0, 3584, 7, 0, 0);

    // CP 40 is clamped to 32 with one err_cp pulse.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd40, 32, 7 * 544, 1'b0);
    settle("cp40_drained");
    chk_counts("cp40", v0, s0, e0, c0, r0, 3584, 7, 1, 0);

    // Resync: new sof at symbol 3, sample 100, new CP 16.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd32, 32, 3 * 544 + 100, 1'b0);
    run_frame(6'd16, 16, 7 * 528, 1'b0);
    settle("resync_drained");
    chk("resync_vld_count", 64'(n_vld - v0), 64'(3 * 512 + 68 + 3584));
    chk("resync_sos_count", 64'(n_sos - s0), 64'd11);
    chk("resync_eos_count", 64'(n_eos - e0), 64'd10);
    chk("resync_err_resync_count", 64'(n_ers - r0), 64'd1);
    chk("resync_err_cp_count", 64'(n_ecp - c0), 64'd0);

    // Reset in the middle of symbol 2, then samples without sof.
    v0 = n_vld;
    run_frame(6'd32, 32, 2 * 544 + 50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_outputs_zero("midframe_reset_outputs");
    chk("midframe_reset_queue", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    for (int n = 0; n < 600; n++) begin
      drive_sample(1'b0, CPW'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0, 0);
    end
    settle("post_reset_drained");
    chk_outputs_zero("post_reset_outputs");
    chk_counts("post_reset", v0, s0, e0, c0, r0, 0, 0, 0, 0);

    // The next sof is accepted normally.
    v0 = n_vld; s0 = n_sos; e0 = n_eos; c0 = n_ecp; r0 = n_ers;
    run_frame(6'd8, 8, 7 * 520, 1'b0);
    settle("after_reset_frame_drained");
    chk_counts("after_reset_frame", v0, s0, e0, c0, r0, 3584, 7, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
